// File: rtl/fetcher_if.sv
// Fetch-stage bus bundle: instruction memory port, branch redirect and issuer handshake.
interface fetcher_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        branchValid;
  logic [31:0] branchTarget;
  logic        readyOut;
  logic [31:0] dataOut;
  logic [31:0] pcOut;
  logic        triggerOut;
  logic        ackIn;

  // Fetcher side
  modport master (
    output imemReq, imemAddr, readyOut, dataOut, pcOut, triggerOut,
    input  imemAck, imemData, branchValid, branchTarget, ackIn
  );

  // Memory / issuer / branch-unit side
  modport slave (
    input  imemReq, imemAddr, readyOut, dataOut, pcOut, triggerOut,
    output imemAck, imemData, branchValid, branchTarget, ackIn
  );
endinterface

// File: rtl/fetcher.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, buffers two words
// and presents the FIFO head to the issuer with a level-valid + toggle handshake.
module fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input logic clk,
  input logic reset,
  fetcher_if.master bus
);

  localparam logic [31:0] RESET_ADDR = RESET_PC & ~32'h3;
  localparam logic [31:0] STEP       = 32'(PC_STEP);

  typedef enum logic [1:0] {FETCH, STALL, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fifoEntry_t;

  state_t      stateQ, stateD;
  logic        reqQ, reqD;
  logic [31:0] addrQ, addrD;
  logic [31:0] targetQ, targetD;
  fifoEntry_t  headQ, headD, tailQ, tailD;
  logic [1:0]  countQ, countD;
  logic        readyQ, readyD;
  logic [31:0] dataQ, dataD;
  logic [31:0] pcQ, pcD;
  logic        trigQ, trigD;
  logic        ackSeenQ, ackSeenD;

  logic        ackValid;
  logic        popEn;
  logic        pushEn;
  logic        newHead;
  logic [31:0] branchAddr;
  fifoEntry_t  incoming;

  assign bus.imemReq    = reqQ;
  assign bus.imemAddr   = addrQ;
  assign bus.readyOut   = readyQ;
  assign bus.dataOut    = dataQ;
  assign bus.pcOut      = pcQ;
  assign bus.triggerOut = trigQ;

  // State register
  always_ff @(posedge clk) begin
    if (reset) stateQ <= FETCH;
    else       stateQ <= stateD;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      reqQ     <= 1'b0;
      addrQ    <= RESET_ADDR;
      targetQ  <= RESET_ADDR;
      headQ    <= '0;
      tailQ    <= '0;
      countQ   <= 2'd0;
      readyQ   <= 1'b0;
      dataQ    <= 32'h0;
      pcQ      <= 32'h0;
      trigQ    <= 1'b0;
      ackSeenQ <= 1'b0;
    end else begin
      reqQ     <= reqD;
      addrQ    <= addrD;
      targetQ  <= targetD;
      headQ    <= headD;
      tailQ    <= tailD;
      countQ   <= countD;
      readyQ   <= readyD;
      dataQ    <= dataD;
      pcQ      <= pcD;
      trigQ    <= trigD;
      ackSeenQ <= ackSeenD;
    end
  end

  // Next-state, FIFO update and presentation logic
  always_comb begin
    stateD   = stateQ;
    reqD     = reqQ;
    addrD    = addrQ;
    targetD  = targetQ;
    headD    = headQ;
    tailD    = tailQ;
    countD   = countQ;
    readyD   = readyQ;
    dataD    = dataQ;
    pcD      = pcQ;
    trigD    = trigQ;
    ackSeenD = bus.ackIn;
    newHead  = 1'b0;
    pushEn   = 1'b0;

    // An ack only counts against a request we actually have outstanding.
    ackValid   = bus.imemAck && reqQ;
    popEn      = (bus.ackIn != ackSeenQ) && (countQ != 2'd0);
    branchAddr = bus.branchTarget & ~32'h3;
    incoming   = {addrQ, bus.imemData};

    if (bus.branchValid) begin
      countD = 2'd0;
      readyD = 1'b0;
      if (stateQ == DRAIN && !ackValid) begin
        targetD = branchAddr;
      end else if (stateQ == FETCH && reqQ && !ackValid) begin
        stateD  = DRAIN;
        targetD = branchAddr;
      end else begin
        stateD = FETCH;
        reqD   = 1'b0;
        addrD  = branchAddr;
      end
    end else begin
      pushEn = ackValid && (stateQ == FETCH);

      case ({pushEn, popEn})
        2'b11: begin
          if (countQ == 2'd1) begin
            headD = incoming;
          end else begin
            headD = tailQ;
            tailD = incoming;
          end
          newHead = 1'b1;
        end
        2'b10: begin
          if (countQ == 2'd0) begin
            headD   = incoming;
            countD  = 2'd1;
            newHead = 1'b1;
          end else begin
            tailD  = incoming;
            countD = 2'd2;
          end
        end
        2'b01: begin
          headD  = tailQ;
          countD = countQ - 2'd1;
          if (countQ == 2'd2) newHead = 1'b1;
          else                readyD  = 1'b0;
        end
        default: ;
      endcase

      if (newHead) begin
        readyD = 1'b1;
        dataD  = headD.data;
        pcD    = headD.pc;
        trigD  = ~trigQ;
      end

      case (stateQ)
        FETCH: begin
          if (ackValid) begin
            reqD  = 1'b0;
            addrD = addrQ + STEP;
            if (countD == 2'd2) stateD = STALL;
          end else if (!reqQ) begin
            if (countD == 2'd2) stateD = STALL;
            else                reqD   = 1'b1;
          end
        end
        STALL: begin
          reqD = 1'b0;
          if (popEn) stateD = FETCH;
        end
        DRAIN: begin
          if (ackValid) begin
            reqD   = 1'b0;
            addrD  = targetQ;
            stateD = FETCH;
          end
        end
        default: stateD = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Directed scoreboard bench for the fetch stage.
module tb_fetcher;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;

  always #5 clk = ~clk;

  fetcher_if bus ();
  fetcher_if bus2 ();

  fetcher #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  fetcher #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dutWrap (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  bit          autoMem = 0;
  int          memLat = 1;
  int          memWait = 0;
  bit          autoPop = 0;
  int          popPeriod = 3;
  int          popCnt = 0;
  logic [31:0] expAddr = 32'h0;
  logic        lastTrig = 1'b0;
  int          headsSeen = 0;
  logic [31:0] wrapAddr[3];
  int          wrapN = 0;

  function automatic logic [31:0] mkData(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h5A5A_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: sample outputs after the edge, score new heads, then drive inputs.
  task automatic tick();
    logic wasReset;
    exp_t e;
    wasReset = reset;
    @(posedge clk);
    #1;
    bus.imemAck     = 1'b0;
    bus.branchValid = 1'b0;

    if (wasReset) begin
      lastTrig = bus.triggerOut;
    end else if (bus.triggerOut !== lastTrig) begin
      lastTrig = bus.triggerOut;
      headsSeen++;
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL spurious head observed pc=%h expected no new head", bus.pcOut);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        check("head pc", bus.pcOut, e.pc);
        check("head data", bus.dataOut, e.data);
        check("head ready", 32'(bus.readyOut), 32'd1);
      end
    end

    if (autoMem && bus.imemReq) begin
      memWait++;
      if (memWait >= memLat) begin
        check("fetch addr", bus.imemAddr, expAddr);
        bus.imemAck  = 1'b1;
        bus.imemData = mkData(expAddr);
        q.push_back({expAddr, mkData(expAddr)});
        expAddr = expAddr + 32'd4;
        memWait = 0;
      end
    end

    if (autoPop) begin
      popCnt++;
      if (popCnt >= popPeriod) begin
        popCnt = 0;
        if (bus.readyOut) bus.ackIn = ~bus.ackIn;
      end
    end

    if (bus2.imemReq && !bus2.imemAck) begin
      if (wrapN < 3) wrapAddr[wrapN] = bus2.imemAddr;
      wrapN++;
      bus2.imemAck  = 1'b1;
      bus2.imemData = mkData(bus2.imemAddr);
    end else begin
      bus2.imemAck = 1'b0;
    end
    if (bus2.readyOut) bus2.ackIn = ~bus2.ackIn;
  endtask

  task automatic doReset();
    reset = 1'b1;
    autoMem = 0;
    autoPop = 0;
    bus.imemAck = 1'b0;
    bus.branchValid = 1'b0;
    bus.ackIn = 1'b0;
    q.delete();
    tick();
    tick();
    check("rst imemReq", 32'(bus.imemReq), 32'd0);
    check("rst imemAddr", bus.imemAddr, 32'h0);
    check("rst readyOut", 32'(bus.readyOut), 32'd0);
    check("rst dataOut", bus.dataOut, 32'h0);
    check("rst pcOut", bus.pcOut, 32'h0);
    check("rst triggerOut", 32'(bus.triggerOut), 32'd0);
    reset = 1'b0;
    expAddr = 32'h0;
    memWait = 0;
    popCnt = 0;
    headsSeen = 0;
  endtask

  task automatic waitReq(input string tag);
    for (int i = 0; i < 10 && !bus.imemReq; i++) tick();
    check(tag, 32'(bus.imemReq), 32'd1);
  endtask

  initial begin
    int h0;
    bus.imemAck = 1'b0;
    bus.imemData = 32'h0;
    bus.branchValid = 1'b0;
    bus.branchTarget = 32'h0;
    bus.ackIn = 1'b0;
    bus2.imemAck = 1'b0;
    bus2.imemData = 32'h0;
    bus2.branchValid = 1'b0;
    bus2.branchTarget = 32'h0;
    bus2.ackIn = 1'b0;

    // 1: streaming with 1-cycle memory and issuer consuming every 3 cycles
    doReset();
    autoMem = 1; memLat = 1; autoPop = 1; popPeriod = 3;
    repeat (40) tick();
    check("t1 heads>=8", 32'(headsSeen >= 8), 32'd1);

    // 2: issuer stalled, FIFO fills to two then one pop restarts fetch
    doReset();
    autoMem = 1; memLat = 1;
    repeat (12) tick();
    check("t2 imemReq", 32'(bus.imemReq), 32'd0);
    check("t2 readyOut", 32'(bus.readyOut), 32'd1);
    check("t2 pcOut", bus.pcOut, 32'h0);
    check("t2 imemAddr", bus.imemAddr, 32'h8);
    check("t2 heads", 32'(headsSeen), 32'd1);
    autoMem = 0;
    bus.ackIn = ~bus.ackIn;
    tick();
    check("t2 heads after pop", 32'(headsSeen), 32'd2);
    waitReq("t2 refetch req");
    check("t2 refetch addr", bus.imemAddr, 32'h8);

    // 3: branch while the 0x8 request waits (latency 4) -> drain, resume at 0x100
    bus.branchValid = 1'b1;
    bus.branchTarget = 32'h103;
    q.delete();
    expAddr = 32'h100;
    tick();
    check("t3 readyOut", 32'(bus.readyOut), 32'd0);
    check("t3 drain req", 32'(bus.imemReq), 32'd1);
    check("t3 drain addr", bus.imemAddr, 32'h8);
    tick();
    tick();
    check("t3 still draining", 32'(bus.imemReq), 32'd1);
    bus.imemAck = 1'b1;
    bus.imemData = 32'hBAD0_BAD0;
    tick();
    check("t3 post-drain req", 32'(bus.imemReq), 32'd0);
    check("t3 post-drain addr", bus.imemAddr, 32'h100);
    check("t3 ready low", 32'(bus.readyOut), 32'd0);
    autoMem = 1; memLat = 1; memWait = 0;
    h0 = headsSeen;
    for (int i = 0; i < 20 && headsSeen == h0; i++) begin
      tick();
      if (headsSeen == h0) check("t3 ready low wait", 32'(bus.readyOut), 32'd0);
    end
    check("t3 target head seen", 32'(headsSeen), 32'(h0 + 1));

    // 4: branch coincident with imemAck and an ackIn toggle
    doReset();
    waitReq("t4 first req");
    bus.imemAck = 1'b1;
    bus.imemData = mkData(32'h0);
    q.push_back({32'h0, mkData(32'h0)});
    tick();
    check("t4 first head", 32'(headsSeen), 32'd1);
    waitReq("t4 second req");
    check("t4 second addr", bus.imemAddr, 32'h4);
    bus.imemAck = 1'b1;
    bus.imemData = 32'h1111_2222;
    bus.branchValid = 1'b1;
    bus.branchTarget = 32'h200;
    bus.ackIn = ~bus.ackIn;
    q.delete();
    tick();
    check("t4 readyOut", 32'(bus.readyOut), 32'd0);
    check("t4 no drain req", 32'(bus.imemReq), 32'd0);
    check("t4 imemAddr", bus.imemAddr, 32'h200);
    check("t4 dataOut held", bus.dataOut, mkData(32'h0));
    tick();
    check("t4 target req", 32'(bus.imemReq), 32'd1);
    check("t4 target addr", bus.imemAddr, 32'h200);

    // 5: PC wrap from a high reset PC
    reset2 = 1'b0;
    repeat (20) tick();
    check("t5 fetch count", 32'(wrapN >= 3), 32'd1);
    check("t5 addr0", wrapAddr[0], 32'hFFFF_FFF8);
    check("t5 addr1", wrapAddr[1], 32'hFFFF_FFFC);
    check("t5 addr2", wrapAddr[2], 32'h0000_0000);

    // 6: reset mid-request with one buffered word; a late ack is ignored
    doReset();
    waitReq("t6 first req");
    bus.imemAck = 1'b1;
    bus.imemData = mkData(32'h0);
    q.push_back({32'h0, mkData(32'h0)});
    tick();
    waitReq("t6 second req");
    reset = 1'b1;
    tick();
    check("t6 imemReq", 32'(bus.imemReq), 32'd0);
    check("t6 imemAddr", bus.imemAddr, 32'h0);
    check("t6 readyOut", 32'(bus.readyOut), 32'd0);
    check("t6 dataOut", bus.dataOut, 32'h0);
    check("t6 pcOut", bus.pcOut, 32'h0);
    check("t6 triggerOut", 32'(bus.triggerOut), 32'd0);
    reset = 1'b0;
    q.delete();
    bus.imemAck = 1'b1;
    bus.imemData = 32'hDEAD_0004;
    tick();
    check("t6 late ack ready", 32'(bus.readyOut), 32'd0);
    check("t6 restart req", 32'(bus.imemReq), 32'd1);
    check("t6 restart addr", bus.imemAddr, 32'h0);
    expAddr = 32'h0; memWait = 0; autoMem = 1; memLat = 1;
    h0 = headsSeen;
    for (int i = 0; i < 10 && headsSeen == h0; i++) tick();
    check("t6 restart head seen", 32'(headsSeen), 32'(h0 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
